// File: rtl/stage2_pkg.sv
// stage2_pkg: shared encodings for the stage-2 multiply/divide unit.
//   OPCODE_OP / FUNCT7_MULDIV : decode constants for RV32M/RV64M register ops
//   funct3_e                  : M-extension operation selector
//   state_e                   : MDU control states
//   op_signed_a / op_signed_b : which operands are treated as two's complement
package stage2_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned.
   function automatic logic op_signed_a(funct3_e f);
      return f inside {MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op_signed_b(funct3_e f);
      return f inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/stage2_muldiv_exec_iter.sv
// muldiv_iter: shared one-bit-per-cycle datapath for the MDU.
//   Multiply mode: {acc,sr} is the shift-add product register (sr starts as
//   the multiplier, b is the multiplicand).
//   Divide mode (only with MDU_DIVIDER_EN): restoring divide, acc is the
//   partial remainder, sr shifts the dividend out and quotient bits in.
// Ports:
//   clk, reset        : clock, async active-high reset
//   load              : clear acc, load sr/b with magnitude operands
//   step              : perform one iteration
//   div_mode          : 1 = divide step (present only with MDU_DIVIDER_EN)
//   init_sr, init_b   : operand magnitudes
//   acc, sr           : high/low halves of the working register
module muldiv_iter
   import stage2_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
`ifdef MDU_DIVIDER_EN
   input  logic            div_mode,
`endif
   input  logic [XLEN-1:0] init_sr,
   input  logic [XLEN-1:0] init_b,
   output logic [XLEN-1:0] acc,
   output logic [XLEN-1:0] sr
);

   logic [XLEN-1:0] b;
   logic [XLEN-1:0] acc_n;
   logic [XLEN-1:0] sr_n;
   logic [XLEN:0]   mul_sum;
`ifdef MDU_DIVIDER_EN
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            borrow;
   logic            unused_diff_top;
`endif

   always_comb begin
      mul_sum = {1'b0, acc} + (sr[0] ? {1'b0, b} : '0);
      acc_n   = mul_sum[XLEN:1];
      sr_n    = {mul_sum[0], sr[XLEN-1:1]};
`ifdef MDU_DIVIDER_EN
      shifted = {acc, sr[XLEN-1]};
      // acc < b always holds, so a successful subtract fits in XLEN bits.
      {borrow, unused_diff_top, diff} = {1'b0, shifted} - {2'b00, b};
      if (div_mode) begin
         acc_n = borrow ? shifted[XLEN-1:0] : diff;
         sr_n  = {sr[XLEN-2:0], ~borrow};
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         sr  <= '0;
         b   <= '0;
      end else if (load) begin
         acc <= '0;
         sr  <= init_sr;
         b   <= init_b;
      end else if (step) begin
         acc <= acc_n;
         sr  <= sr_n;
      end
   end

endmodule

// File: rtl/stage2_muldiv_exec.sv
// stage2_muldiv_exec: multi-cycle RV32M/RV64M multiply/divide unit beside the
// stage-2 ALU. Forwards writeback data onto raw regfile operands, runs an
// XLEN-cycle shift-add multiply or restoring divide on magnitudes, and fixes
// up signs when presenting the result in DONE.
// Build option: MDU_DIVIDER_EN. When undefined the divider is not built and
// funct3[2]=1 ops finish after one cycle with illegal=1 and result=0.
// Ports:
//   clk, reset            : clock, async active-high reset
//   stall                 : downstream stall, holds a finished result in DONE
//   flush                 : kill the in-flight op
//   valid_in, inst        : stage-2 instruction
//   rs1d, rs2d            : regfile operands
//   wb_data_w/rwe_w/rd_w  : writeback forwarding source
//   is_mdu                : inst is an M-extension OP
//   busy                  : stall request to the hazard unit
//   result, result_valid  : finished result, valid in DONE
//   illegal               : op not supported in this build
module stage2_muldiv_exec
   import stage2_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            valid_in,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] rs1d,
   input  logic [XLEN-1:0] rs2d,
   input  logic [XLEN-1:0] wb_data_w,
   input  logic            rwe_w,
   input  logic [4:0]      rd_w,
   output logic            is_mdu,
   output logic            busy,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            illegal
);

   state_e            state, state_n;
   funct3_e           op_in, op;
   logic [CNT_W-1:0]  cnt;
   logic              neg;
   logic [XLEN-1:0]   a, b, mag_a, mag_b;
   logic              sa, sb, start, op_ok, last;
   logic [XLEN-1:0]   acc, sr, res;
   logic [2*XLEN-1:0] prod;
   logic              unused_rd_field;
`ifdef MDU_DIVIDER_EN
   logic              div_zero;
`endif

   assign unused_rd_field = ^inst[11:7];

   assign op_in  = funct3_e'(inst[14:12]);
   assign is_mdu = (inst[6:0] == OPCODE_OP) && (inst[31:25] == FUNCT7_MULDIV);

   assign a = (rwe_w && rd_w != 5'd0 && rd_w == inst[19:15]) ? wb_data_w : rs1d;
   assign b = (rwe_w && rd_w != 5'd0 && rd_w == inst[24:20]) ? wb_data_w : rs2d;

   assign sa    = op_signed_a(op_in) && a[XLEN-1];
   assign sb    = op_signed_b(op_in) && b[XLEN-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

`ifdef MDU_DIVIDER_EN
   assign op_ok = 1'b1;
`else
   assign op_ok = ~inst[14];
`endif

   assign start        = valid_in && is_mdu && (state == IDLE) && !flush;
   assign busy         = start || (state == RUN);
   assign result_valid = (state == DONE);
   assign last         = (cnt == CNT_W'(1));

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_n = op_ok ? RUN : DONE;
            RUN:     if (last) state_n = DONE;
            DONE:    if (!stall) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         op       <= MUL;
         neg      <= 1'b0;
         illegal  <= 1'b0;
`ifdef MDU_DIVIDER_EN
         div_zero <= 1'b0;
`endif
      end else if (start) begin
         cnt      <= CNT_W'(XLEN);
         op       <= op_in;
         illegal  <= !op_ok;
         // Remainder sign follows the dividend; everything else uses sa^sb.
         neg      <= (op_in == REM || op_in == REMU) ? sa : (sa ^ sb);
`ifdef MDU_DIVIDER_EN
         div_zero <= (b == '0);
`endif
      end else begin
         if (state == RUN) cnt <= cnt - CNT_W'(1);
         if (state_n == IDLE) illegal <= 1'b0;
      end
   end

   muldiv_iter #(
      .XLEN(XLEN)
   ) u_iter (
      .clk      (clk),
      .reset    (reset),
      .load     (start && op_ok),
      .step     (state == RUN),
`ifdef MDU_DIVIDER_EN
      .div_mode (op[2]),
`endif
      .init_sr  (mag_a),
      .init_b   (mag_b),
      .acc      (acc),
      .sr       (sr)
   );

   // Working registers are frozen in DONE, so the fixed-up result is stable.
   always_comb begin
      prod = {acc, sr};
      if (neg) prod = -prod;
      res = '0;
      case (op)
         MUL:                 res = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: res = prod[2*XLEN-1:XLEN];
`ifdef MDU_DIVIDER_EN
         DIV, DIVU:           res = div_zero ? '1 : (neg ? -sr : sr);
         REM, REMU:           res = neg ? -acc : acc;
`endif
         default:             res = '0;
      endcase
      result = (state == DONE && !illegal) ? res : '0;
   end

endmodule

// File: tb/tb_stage2_muldiv_exec.sv
// Directed bench for stage2_muldiv_exec at XLEN=32. Divide checks are built
// when MDU_DIVIDER_EN is defined; otherwise the illegal-op path is checked.
module tb_stage2_muldiv_exec;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                          F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                          F_REM = 3'b110, F_REMU = 3'b111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] inst = '0;
   logic [31:0] rs1d = '0;
   logic [31:0] rs2d = '0;
   logic [31:0] wb_data_w = '0;
   logic        rwe_w = 1'b0;
   logic [4:0]  rd_w = '0;
   logic        is_mdu, busy, result_valid, illegal;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   stage2_muldiv_exec #(.XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .valid_in     (valid_in),
      .inst         (inst),
      .rs1d         (rs1d),
      .rs2d         (rs2d),
      .wb_data_w    (wb_data_w),
      .rwe_w        (rwe_w),
      .rd_w         (rd_w),
      .is_mdu       (is_mdu),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents an M op in the cycle following the next rising edge.
   task automatic issue(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      inst     = {7'b0000001, r2, r1, f3, 5'd3, 7'b0110011};
      rs1d     = a;
      rs2d     = b;
      valid_in = 1'b1;
   endtask

   // Returns at the negedge of the first DONE cycle (lat = cycles after start).
   task automatic wait_done(output int lat, output int bcyc, output logic [31:0] res,
                            output logic ill);
      lat = -1; bcyc = 0; res = '0; ill = 1'b0;
      @(negedge clk);
      if (busy) bcyc++;
      @(posedge clk); #1;
      valid_in  = 1'b0;
      rs1d      = 32'hDEAD_BEEF;
      rs2d      = 32'h1357_9BDF;
      wb_data_w = 32'hCAFE_F00D;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (busy) bcyc++;
         if (result_valid) begin
            lat = c; res = result; ill = illegal;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (result !== 32'h0 || result_valid !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got res=%h rv=%b ill=%b busy=%b want 0/0/0/0",
                  result, result_valid, illegal, busy);
      end
      reset = 1'b0;
      inst = {7'b0000001, 5'd2, 5'd1, F_MUL, 5'd3, 7'b0110011};
      #1 checks++;
      if (is_mdu !== 1'b1) begin failures++; $display("FAIL is_mdu_mul got=%b want=1", is_mdu); end
      inst = {7'b0000001, 5'd2, 5'd1, F_MUL, 5'd3, 7'b0111011};
      #1 checks++;
      if (is_mdu !== 1'b0) begin failures++; $display("FAIL is_mdu_wform got=%b want=0", is_mdu); end
      inst = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
      valid_in = 1'b1;
      #1 checks++;
      if (is_mdu !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL non_mdu_add got is_mdu=%b busy=%b want 0/0", is_mdu, busy);
      end
      repeat (3) @(posedge clk);
      #1 valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin failures++; $display("FAIL non_mdu_idle rv=%b want=0", result_valid); end
   endtask

   task automatic test_mul();
      logic [2:0]  f3s [7] = '{F_MUL, F_MULHU, F_MULH, F_MULHSU, F_MUL, F_MULH, F_MULHU};
      logic [31:0] as  [7] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] bs  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'h10, 32'd2, 32'd4};
      logic [31:0] exp [7] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'h23456780, 32'hFFFFFFFF, 32'd2};
      int lat, bcyc; logic [31:0] res; logic ill;
      for (int i = 0; i < 7; i++) begin
         issue(f3s[i], 5'd1, 5'd2, as[i], bs[i]);
         wait_done(lat, bcyc, res, ill);
         checks++;
         if (res !== exp[i] || ill !== 1'b0) begin
            failures++; $display("FAIL mul_result[%0d] got=%h ill=%b want=%h ill=0", i, res, ill, exp[i]);
         end
         checks++;
         if (lat !== 33 || bcyc !== 33) begin
            failures++; $display("FAIL mul_latency[%0d] got lat=%0d busy=%0d want 33/33", i, lat, bcyc);
         end
      end
   endtask

`ifdef MDU_DIVIDER_EN
   task automatic test_div();
      logic [2:0]  f3s [12] = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM, F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM};
      logic [31:0] as  [12] = '{32'h80000000, 32'h80000000, 32'd5, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd5, 32'hFFFFFFFB, 32'd100, 32'd100, 32'd20, 32'd20};
      logic [31:0] bs  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'd7, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFA};
      logic [31:0] exp [12] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFB, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd2};
      int lat, bcyc; logic [31:0] res; logic ill;
      for (int i = 0; i < 12; i++) begin
         issue(f3s[i], 5'd1, 5'd2, as[i], bs[i]);
         wait_done(lat, bcyc, res, ill);
         checks++;
         if (res !== exp[i] || ill !== 1'b0 || lat !== 33) begin
            failures++;
            $display("FAIL div_result[%0d] got=%h ill=%b lat=%0d want=%h ill=0 lat=33", i, res, ill, lat, exp[i]);
         end
      end
   endtask
`else
   task automatic test_illegal();
      int lat, bcyc; logic [31:0] res; logic ill;
      issue(F_DIV, 5'd1, 5'd2, 32'd20, 32'd3);
      wait_done(lat, bcyc, res, ill);
      checks++;
      if (ill !== 1'b1 || res !== 32'h0 || lat !== 1 || bcyc !== 1) begin
         failures++;
         $display("FAIL illegal_div got ill=%b res=%h lat=%0d busy=%0d want 1/0/1/1", ill, res, lat, bcyc);
      end
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (result_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0) begin
            failures++;
            $display("FAIL illegal_hold[%0d] got rv=%b ill=%b res=%h want 1/1/0", i, result_valid, illegal, result);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || illegal !== 1'b0) begin
         failures++; $display("FAIL illegal_exit got rv=%b ill=%b want 0/0", result_valid, illegal);
      end
      issue(F_MUL, 5'd1, 5'd2, 32'd6, 32'd7);
      wait_done(lat, bcyc, res, ill);
      checks++;
      if (res !== 32'd42 || ill !== 1'b0 || lat !== 33) begin
         failures++; $display("FAIL mul_after_illegal got=%h ill=%b lat=%0d want=0000002a 0 33", res, ill, lat);
      end
   endtask
`endif

   task automatic test_forward();
      logic [4:0]  rdw [4] = '{5'd5, 5'd0, 5'd6, 5'd5};
      logic        rwe [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0]  r1s [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
      logic [31:0] as  [4] = '{32'd1, 32'd1, 32'd3, 32'd1};
      logic [31:0] exp [4] = '{32'd36, 32'd4, 32'd27, 32'd4};
      int lat, bcyc; logic [31:0] res; logic ill;
      for (int i = 0; i < 4; i++) begin
         rd_w = rdw[i]; rwe_w = rwe[i]; wb_data_w = 32'd9;
         issue(F_MUL, r1s[i], 5'd6, as[i], 32'd4);
         wait_done(lat, bcyc, res, ill);
         checks++;
         if (res !== exp[i]) begin
            failures++; $display("FAIL forward[%0d] got=%h want=%h", i, res, exp[i]);
         end
      end
      rwe_w = 1'b0; rd_w = '0;
   endtask

   task automatic test_stall();
      int lat, bcyc; logic [31:0] res; logic ill;
      issue(F_MUL, 5'd1, 5'd2, 32'd3, 32'd5);
      wait_done(lat, bcyc, res, ill);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (result_valid !== 1'b1 || result !== 32'd15) begin
            failures++; $display("FAIL stall_hold[%0d] got rv=%b res=%h want 1/0000000f", i, result_valid, result);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL stall_release got rv=%b busy=%b want 0/0", result_valid, busy);
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      issue(F_MUL, 5'd1, 5'd2, 32'd3, 32'd5);
      @(posedge clk); #1 valid_in = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b want=1", busy); end
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         failures++; $display("FAIL flush_idle got busy=%b rv=%b want 0/0", busy, result_valid);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL flush_no_result got rv_cycles=%0d want=0", seen); end
   endtask

   task automatic test_reset_mid();
      int lat, bcyc; logic [31:0] res; logic ill;
      issue(F_MUL, 5'd1, 5'd2, 32'd3, 32'd5);
      @(posedge clk); #1 valid_in = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
      reset = 1'b1;
      #1 checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0 || illegal !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_run got busy=%b rv=%b res=%h ill=%b want 0/0/0/0", busy, result_valid, result, illegal);
      end
      @(posedge clk); #1 reset = 1'b0;
      issue(F_MUL, 5'd1, 5'd2, 32'd3, 32'd5);
      wait_done(lat, bcyc, res, ill);
      stall = 1'b1;
      @(posedge clk); #2 reset = 1'b1;
      #1 checks++;
      if (result_valid !== 1'b0 || result !== 32'h0) begin
         failures++; $display("FAIL rst_in_done got rv=%b res=%h want 0/0", result_valid, result);
      end
      @(posedge clk); #1 reset = 1'b0; stall = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat, bcyc; logic [31:0] res; logic ill;
      issue(F_MUL, 5'd1, 5'd2, 32'd11, 32'd13);
      wait_done(lat, bcyc, res, ill);
      checks++;
      if (res !== 32'd143) begin failures++; $display("FAIL b2b_first got=%h want=0000008f", res); end
      issue(F_MULHU, 5'd1, 5'd2, 32'h00010000, 32'h00030000);
      wait_done(lat, bcyc, res, ill);
      checks++;
      if (res !== 32'd3 || lat !== 33 || bcyc !== 33) begin
         failures++; $display("FAIL b2b_second got=%h lat=%0d busy=%0d want=00000003 33 33", res, lat, bcyc);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
`ifdef MDU_DIVIDER_EN
      test_div();
`else
      test_illegal();
`endif
      test_forward();
      test_stall();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
